// File: rtl/datapath_controller_pkg.sv
// Shared types and encodings for the Simple RISC datapath controller.
package datapath_controller_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_ALU    = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    // nsel is one-hot towards the decoder's register-number mux
    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_CMP     = 2'b01;

    typedef struct packed {
        logic [2:0] opc;
        logic [1:0] op;
    } ir_op_t;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_mov_imm(input ir_op_t ir);
        return (ir.opc == OPC_MOV) && (ir.op == OP_MOV_IMM);
    endfunction

    function automatic logic is_mov_reg(input ir_op_t ir);
        return (ir.opc == OPC_MOV) && (ir.op == OP_MOV_REG);
    endfunction

    function automatic logic is_alu(input ir_op_t ir);
        return ir.opc == OPC_ALU;
    endfunction

    function automatic logic is_cmp(input ir_op_t ir);
        return (ir.opc == OPC_ALU) && (ir.op == OP_CMP);
    endfunction

    // Control word presented while idle: only w is high
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c      = '0;
        c.w    = 1'b1;
        c.nsel = NSEL_NONE;
        c.vsel = VSEL_C;
        return c;
    endfunction

endpackage

// File: rtl/datapath_controller_state_reg.sv
// State register for the datapath controller: plain DFF bank with a
// synchronous active-low reset to a configurable value.
module datapath_controller_state_reg #(
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture next state, forcing the reset value while reset_n is low
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/datapath_controller.sv
// Moore controller sequencing the Simple RISC datapath, one instruction
// per s pulse.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  S_WAIT   | idle, w=1, samples s and latches {opcode,op}
//  S_DECODE | inspect latched op; flags illegal and returns if unsupported
//  S_GET_A  | read Rn into A
//  S_GET_B  | read Rm into B
//  S_ALU    | compute into C and/or status (CMP finishes here)
//  S_WR_REG | write C back to Rd
//  S_WR_IMM | write sximm8 to Rn
//
// Outputs are registered from the next state and next latched op, so they
// change on the same edge as the state and depend only on state + ir_op.
module datapath_controller
    import datapath_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       illegal
);

    logic [ST_W-1:0] state_raw;
    state_t          state;
    state_t          state_nxt;
    ir_op_t          ir_op;
    ir_op_t          ir_op_nxt;
    ctrl_t           ctrl_q;
    ctrl_t           ctrl_nxt;

    datapath_controller_state_reg #(
        .W       (ST_W),
        .RST_VAL (S_WAIT)
    ) u_state_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (state_nxt),
        .q       (state_raw)
    );

    assign state = state_t'(state_raw);

    // Control word for a given state and latched instruction
    function automatic ctrl_t decode_ctrl(input state_t st, input ir_op_t ir);
        ctrl_t c;
        c = '0;
        case (st)
            S_WAIT: c = ctrl_idle();
            S_DECODE: c.illegal = !(is_mov_imm(ir) || is_mov_reg(ir) || is_alu(ir));
            S_GET_A: begin
                c.nsel  = NSEL_RN;
                c.loada = 1'b1;
            end
            S_GET_B: begin
                c.nsel  = NSEL_RM;
                c.loadb = 1'b1;
            end
            S_ALU: begin
                c.asel  = is_mov_reg(ir);
                c.loadc = !is_cmp(ir);
                c.loads = !is_mov_reg(ir);
            end
            S_WR_REG: begin
                c.nsel  = NSEL_RD;
                c.vsel  = VSEL_C;
                c.write = 1'b1;
            end
            S_WR_IMM: begin
                c.nsel  = NSEL_RN;
                c.vsel  = VSEL_IMM8;
                c.write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic; unknown encodings fall back to S_WAIT
    always_comb begin
        state_nxt = S_WAIT;
        ir_op_nxt = ir_op;
        case (state)
            S_WAIT: begin
                if (s) begin
                    ir_op_nxt.opc = opcode;
                    ir_op_nxt.op  = op;
                    state_nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm(ir_op)) begin
                    state_nxt = S_WR_IMM;
                end else if (is_mov_reg(ir_op)) begin
                    state_nxt = S_GET_B;
                end else if (is_alu(ir_op)) begin
                    state_nxt = S_GET_A;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_GET_A:  state_nxt = S_GET_B;
            S_GET_B:  state_nxt = S_ALU;
            S_ALU:    state_nxt = is_cmp(ir_op) ? S_WAIT : S_WR_REG;
            S_WR_REG: state_nxt = S_WAIT;
            S_WR_IMM: state_nxt = S_WAIT;
            default:  state_nxt = S_WAIT;
        endcase
    end

    // Output decode for the state being entered
    always_comb begin
        ctrl_nxt = decode_ctrl(state_nxt, ir_op_nxt);
    end

    // Latched instruction and registered control word; reset drops every enable
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir_op  <= '0;
            ctrl_q <= ctrl_idle();
        end else begin
            ir_op  <= ir_op_nxt;
            ctrl_q <= ctrl_nxt;
        end
    end

    assign w       = ctrl_q.w;
    assign nsel    = ctrl_q.nsel;
    assign vsel    = ctrl_q.vsel;
    assign write   = ctrl_q.write;
    assign loada   = ctrl_q.loada;
    assign loadb   = ctrl_q.loadb;
    assign loadc   = ctrl_q.loadc;
    assign loads   = ctrl_q.loads;
    assign asel    = ctrl_q.asel;
    assign bsel    = ctrl_q.bsel;
    assign illegal = ctrl_q.illegal;

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench for datapath_controller: each instruction is expanded
// into its expected per-cycle list of datapath actions and compared cycle by cycle.
module tb_datapath_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_q[$];

    datapath_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s       (s),
        .opcode  (opcode),
        .op      (op),
        .w       (w),
        .nsel    (nsel),
        .vsel    (vsel),
        .write   (write),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    // Observed outputs as {w,nsel,vsel,write,loada,loadb,loadc,loads,asel,bsel,illegal}
    function automatic logic [13:0] obs();
        return {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, illegal};
    endfunction

    function automatic logic [13:0] mk(input logic iw, input logic [2:0] ns, input logic [1:0] vs,
                                       input logic wr, input logic la, input logic lb,
                                       input logic lc, input logic ls, input logic as,
                                       input logic il);
        return {iw, ns, vs, wr, la, lb, lc, ls, as, 1'b0, il};
    endfunction

    // Reference model: the list of datapath actions an instruction needs,
    // one entry per cycle after s is taken, ending with the idle cycle.
    function automatic void model_push(input logic [2:0] opc, input logic [1:0] o);
        bit mov_imm = (opc == 3'b110) && (o == 2'b10);
        bit mov_reg = (opc == 3'b110) && (o == 2'b00);
        bit alu     = (opc == 3'b101);
        bit cmp     = alu && (o == 2'b01);
        // decode cycle: nothing enabled, flag unsupported instructions
        exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, !(mov_imm || mov_reg || alu)));
        if (mov_imm)
            exp_q.push_back(mk(0, 3'b100, 2'b10, 1, 0, 0, 0, 0, 0, 0));
        if (alu)
            exp_q.push_back(mk(0, 3'b100, 2'b00, 0, 1, 0, 0, 0, 0, 0));
        if (alu || mov_reg) begin
            exp_q.push_back(mk(0, 3'b001, 2'b00, 0, 0, 1, 0, 0, 0, 0));
            exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, !cmp, !mov_reg, mov_reg, 0));
        end
        if (mov_reg || (alu && !cmp))
            exp_q.push_back(mk(0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        s       = 1'b1;
        opcode  = 3'b110;
        op      = 2'b10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== mk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL reset cyc%0d got %b exp %b", i,
                         obs(), mk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
            end
        end
        reset_n = 1'b1;
        s       = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== mk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", obs(),
                     mk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    // One instruction from idle; s and opcode/op are noise after the start edge
    task automatic test_instr(input string name, input logic [2:0] opc, input logic [1:0] o);
        logic [13:0] e;
        int          cyc = 0;
        exp_q.delete();
        model_push(opc, o);
        s      = 1'b1;
        opcode = opc;
        op     = o;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            cyc++;
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL %s c%0d got %b exp %b", name, cyc, obs(), e);
            end
            checks++;
            if ($countones({loada, loadb, loadc, write}) > 1) begin
                errors++;
                $display("FAIL %s_onehot c%0d got %b exp at most one", name, cyc,
                         {loada, loadb, loadc, write});
            end
            s      = (exp_q.size() == 0) ? 1'b0 : 1'($urandom);
            opcode = 3'($urandom);
            op     = 2'($urandom);
        end
    endtask

    task automatic test_random();
        logic [2:0] opc;
        logic [1:0] o;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                opc = 3'($urandom);
                o   = 2'($urandom);
            end else begin
                opc = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b101;
                o   = 2'($urandom);
            end
            test_instr("random", opc, o);
        end
    endtask

    // s held high from idle: instructions chain with one idle cycle between
    task automatic test_back_to_back(input int count);
        logic [13:0] e;
        int          cyc = 0;
        int          writes = 0;
        exp_q.delete();
        for (int i = 0; i < count; i++) model_push(3'b110, 2'b10);
        s      = 1'b1;
        opcode = 3'b110;
        op     = 2'b10;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            cyc++;
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL b2b c%0d got %b exp %b", cyc, obs(), e);
            end
            if (write === 1'b1) writes++;
            if (exp_q.size() == 0) s = 1'b0;
        end
        checks++;
        if (writes != count) begin
            errors++;
            $display("FAIL b2b_writes got %0d exp %0d", writes, count);
        end
    endtask

    // Reset while ADD sits in its read-Rm cycle; s kept high through reset
    task automatic test_mid_reset();
        logic [13:0] e;
        exp_q.delete();
        model_push(3'b101, 2'b00);
        s      = 1'b1;
        opcode = 3'b101;
        op     = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL midrst_pre c%0d got %b exp %b", i + 1, obs(), e);
            end
            s = 1'b0;
        end
        reset_n = 1'b0;
        s       = 1'b1;
        opcode  = 3'b110;
        op      = 2'b10;
        @(negedge clk);
        checks++;
        if (obs() !== mk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL midrst_idle got %b exp %b", obs(),
                     mk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        end
        reset_n = 1'b1;
        test_back_to_back(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        s       = 1'b0;
        opcode  = 3'b000;
        op      = 2'b00;
        test_reset();
        test_instr("mov_imm", 3'b110, 2'b10);
        test_instr("add",     3'b101, 2'b00);
        test_instr("cmp",     3'b101, 2'b01);
        test_instr("and",     3'b101, 2'b10);
        test_instr("mvn",     3'b101, 2'b11);
        test_instr("mov_reg", 3'b110, 2'b00);
        test_instr("illegal", 3'b111, 2'b11);
        test_instr("ill_mov", 3'b110, 2'b01);
        test_back_to_back(3);
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
